// File: rtl/gon_glb_writeback.sv
// gon_glb_writeback: drains the GON output stream into the global buffer at
// sequential word addresses starting from a programmed base, then reports done.
// Optional feature macro: GON_GLB_ACCUM_EN -- when defined, each word is added
// to the current GLB content (read-modify-write) before being written back.
module gon_glb_writeback #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 12,
  parameter int CNT_BITS  = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [CNT_BITS-1:0]  num_words,
  input  logic                 GON_valid,
  output logic                 GON_ready,
  input  logic [DATA_BITS-1:0] GON_data,
  output logic                 glb_re,
  output logic                 glb_we,
  output logic [ADDR_BITS-1:0] glb_addr,
  output logic [DATA_BITS-1:0] glb_wdata,
  input  logic [DATA_BITS-1:0] glb_rdata,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
`ifdef GON_GLB_ACCUM_EN
    RD,
    ADD,
`endif
    WR,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [CNT_BITS-1:0]  num_q, num_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [DATA_BITS-1:0] dreg_q, dreg_d;

  // Every output is a registered copy of a decode of the next state, so it
  // lines up cycle-for-cycle with the state register and never depends
  // combinationally on GON_valid.
  logic                 gon_ready_q, gon_ready_d;
  logic                 glb_re_q, glb_re_d;
  logic                 glb_we_q, glb_we_d;
  logic [ADDR_BITS-1:0] glb_addr_q, glb_addr_d;
  logic [DATA_BITS-1:0] glb_wdata_q, glb_wdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Next-state, datapath and output-decode logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    dreg_d      = dreg_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            base_d  = base_addr;
            num_d   = num_words;
            cnt_d   = '0;
            state_d = RECV;
          end else begin
            state_d = DONE;
          end
        end
      end
      RECV: begin
        if (GON_valid && gon_ready_q) begin
          dreg_d  = GON_data;
`ifdef GON_GLB_ACCUM_EN
          state_d = RD;
`else
          state_d = WR;
`endif
        end
      end
`ifdef GON_GLB_ACCUM_EN
      RD: begin
        state_d = ADD;
      end
      ADD: begin
        // Wraps modulo 2^DATA_BITS; psum overflow is not saturated.
        dreg_d  = dreg_q + glb_rdata;
        state_d = WR;
      end
`endif
      WR: begin
        cnt_d   = cnt_q + CNT_BITS'(1);
        state_d = (cnt_d == num_q) ? DONE : RECV;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    gon_ready_d = (state_d == RECV);
    glb_we_d    = (state_d == WR);
    glb_re_d    = 1'b0;
    busy_d      = (state_d == RECV) || (state_d == WR);
`ifdef GON_GLB_ACCUM_EN
    glb_re_d    = (state_d == RD);
    busy_d      = busy_d || (state_d == RD) || (state_d == ADD);
`endif
    done_d      = (state_d == DONE);

    // Address wraps past the top of the GLB because the sum is truncated.
    glb_addr_d  = glb_addr_q;
    if (glb_we_d || glb_re_d) begin
      glb_addr_d = base_d + cnt_d[ADDR_BITS-1:0];
    end
    glb_wdata_d = glb_we_d ? dreg_d : glb_wdata_q;
  end

  // State and output registers with synchronous active-low reset; a reset in
  // mid-transfer simply returns everything to idle without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      dreg_q      <= '0;
      gon_ready_q <= 1'b0;
      glb_re_q    <= 1'b0;
      glb_we_q    <= 1'b0;
      glb_addr_q  <= '0;
      glb_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      dreg_q      <= dreg_d;
      gon_ready_q <= gon_ready_d;
      glb_re_q    <= glb_re_d;
      glb_we_q    <= glb_we_d;
      glb_addr_q  <= glb_addr_d;
      glb_wdata_q <= glb_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifndef GON_GLB_ACCUM_EN
  // Read data is only consumed by the accumulate path.
  logic unused_rdata;
  assign unused_rdata = ^glb_rdata;
`endif

  assign GON_ready = gon_ready_q;
  assign glb_re    = glb_re_q;
  assign glb_we    = glb_we_q;
  assign glb_addr  = glb_addr_q;
  assign glb_wdata = glb_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gon_glb_writeback.sv
// Directed testbench for gon_glb_writeback: GLB memory model, write/read
// logging, and one task per scenario with hand-computed expectations.
module tb_gon_glb_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] num_words = '0;
  logic        GON_valid = 1'b0;
  logic        GON_ready;
  logic [31:0] GON_data = '0;
  logic        glb_re;
  logic        glb_we;
  logic [11:0] glb_addr;
  logic [31:0] glb_wdata;
  logic [31:0] glb_rdata;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  gon_glb_writeback #(
    .DATA_BITS(32),
    .ADDR_BITS(12),
    .CNT_BITS (13)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .num_words(num_words),
    .GON_valid(GON_valid),
    .GON_ready(GON_ready),
    .GON_data (GON_data),
    .glb_re   (glb_re),
    .glb_we   (glb_we),
    .glb_addr (glb_addr),
    .glb_wdata(glb_wdata),
    .glb_rdata(glb_rdata),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // GLB model: synchronous write, read data valid the cycle after glb_re.
  logic [31:0] mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (glb_we) mem[glb_addr] <= glb_wdata;
    if (glb_re) glb_rdata <= mem[glb_addr];
  end

  // Activity logs.
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t wr_log[$];
  int  re_cyc[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  overlap = 0;

  always @(posedge clk) begin
    wr_t e;
    cyc <= cyc + 1;
    if (glb_we) begin
      e.addr = glb_addr;
      e.data = glb_wdata;
      e.cyc  = cyc;
      wr_log.push_back(e);
    end
    if (glb_re) re_cyc.push_back(cyc);
    if (done) done_cnt <= done_cnt + 1;
    if (glb_we && glb_re) overlap <= overlap + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------- helpers
  task automatic do_start(input logic [11:0] b, input logic [12:0] n);
    @(negedge clk);
    start = 1'b1; base_addr = b; num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one word and hold it until accepted; returns at the negedge after the handshake.
  task automatic send_word(input logic [31:0] d, output bit ok);
    ok = 1'b0;
    GON_valid = 1'b1;
    GON_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (GON_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    GON_valid = 1'b0;
  endtask

  // Returns at the negedge of the cycle where done is high.
  task automatic wait_done(input int budget, output bit seen, output int at_cyc);
    seen = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        at_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({GON_ready, glb_re, glb_we, busy, done} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000", {GON_ready, glb_re, glb_we, busy, done});
    end
    vectors++;
    if (glb_addr !== 12'h000 || glb_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h wdata=%h want 000/00000000", glb_addr, glb_wdata);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plain;
    logic [9:0] exp_rdy, exp_we, exp_busy, exp_done;
    logic [9:0] got_rdy, got_we, got_busy, got_done;
    int lb, k;
    exp_rdy  = 10'b1010101000;
    exp_we   = 10'b0101010100;
    exp_busy = 10'b1111111100;
    exp_done = 10'b0000000010;
    lb = wr_log.size();
    k  = 0;
    do_start(12'h010, 13'd4);
    GON_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      got_rdy[9-i]  = GON_ready;
      got_we[9-i]   = glb_we;
      got_busy[9-i] = busy;
      got_done[9-i] = done;
      GON_data = 32'(k + 1);
      if (GON_ready) k++;
      @(negedge clk);
    end
    GON_valid = 1'b0;
    vectors++;
    if (got_rdy !== exp_rdy) begin
      miscompares++;
      $display("FAIL plain_ready_pattern: got %b want %b", got_rdy, exp_rdy);
    end
    vectors++;
    if (got_we !== exp_we) begin
      miscompares++;
      $display("FAIL plain_we_pattern: got %b want %b", got_we, exp_we);
    end
    vectors++;
    if (got_busy !== exp_busy) begin
      miscompares++;
      $display("FAIL plain_busy_pattern: got %b want %b", got_busy, exp_busy);
    end
    vectors++;
    if (got_done !== exp_done) begin
      miscompares++;
      $display("FAIL plain_done_pattern: got %b want %b", got_done, exp_done);
    end
    vectors++;
    if (wr_log.size() - lb != 4) begin
      miscompares++;
      $display("FAIL plain_write_count: got %0d want 4", wr_log.size() - lb);
    end else begin
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (wr_log[lb+j].addr !== 12'(16 + j) || wr_log[lb+j].data !== 32'(j + 1)) begin
          miscompares++;
          $display("FAIL plain_write%0d: got %h/%h want %h/%h", j,
                   wr_log[lb+j].addr, wr_log[lb+j].data, 12'(16 + j), 32'(j + 1));
        end
      end
    end
  endtask

  task automatic test_stall;
    bit ok, seen;
    int lb, dc, dcyc, gap_bad;
    logic [31:0] words [3];
    words[0] = 32'h0000_00A1; words[1] = 32'h0000_00A2; words[2] = 32'h0000_00A3;
    lb = wr_log.size();
    dc = done_cnt;
    gap_bad = 0;
    do_start(12'h040, 13'd3);
    send_word(words[0], ok);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (GON_ready !== 1'b1 || glb_we !== 1'b0) gap_bad++;
      @(negedge clk);
    end
    vectors++;
    if (gap_bad != 0) begin
      miscompares++;
      $display("FAIL stall_gap: got %0d bad gap cycles want 0", gap_bad);
    end
    send_word(words[1], ok);
    send_word(words[2], ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL stall_accept: got no handshake want handshake");
    end
    wait_done(20, seen, dcyc);
    @(negedge clk);
    vectors++;
    if (!seen || done_cnt - dc != 1) begin
      miscompares++;
      $display("FAIL stall_done: got seen=%0d pulses=%0d want 1/1", seen, done_cnt - dc);
    end
    vectors++;
    if (wr_log.size() - lb != 3) begin
      miscompares++;
      $display("FAIL stall_write_count: got %0d want 3", wr_log.size() - lb);
    end else begin
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (wr_log[lb+j].addr !== 12'(12'h040 + j) || wr_log[lb+j].data !== words[j]) begin
          miscompares++;
          $display("FAIL stall_write%0d: got %h/%h want %h/%h", j,
                   wr_log[lb+j].addr, wr_log[lb+j].data, 12'(12'h040 + j), words[j]);
        end
      end
      vectors++;
      if (dcyc != wr_log[lb+2].cyc + 1) begin
        miscompares++;
        $display("FAIL stall_done_timing: got cycle %0d want %0d", dcyc, wr_log[lb+2].cyc + 1);
      end
    end
  endtask

  task automatic test_zero_wrap;
    bit ok, seen;
    int lb, dcyc;
    logic [11:0] exp_addr [4];
    exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
    lb = wr_log.size();
    do_start(12'h123, 13'd0);
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL zero_done: got done,busy=%b want 10", {done, busy});
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || wr_log.size() != lb) begin
      miscompares++;
      $display("FAIL zero_after: got done=%b writes=%0d want 0/0", done, wr_log.size() - lb);
    end
    lb = wr_log.size();
    do_start(12'hFFE, 13'd4);
    for (int j = 0; j < 4; j++) send_word(32'(32'h11 + j), ok);
    wait_done(20, seen, dcyc);
    @(negedge clk);
    vectors++;
    if (!seen || wr_log.size() - lb != 4) begin
      miscompares++;
      $display("FAIL wrap_count: got seen=%0d writes=%0d want 1/4", seen, wr_log.size() - lb);
    end else begin
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (wr_log[lb+j].addr !== exp_addr[j] || wr_log[lb+j].data !== 32'(32'h11 + j)) begin
          miscompares++;
          $display("FAIL wrap_write%0d: got %h/%h want %h/%h", j,
                   wr_log[lb+j].addr, wr_log[lb+j].data, exp_addr[j], 32'(32'h11 + j));
        end
      end
    end
  endtask

  task automatic test_start_ignored;
    bit ok, seen;
    int lb, dc, dcyc;
    lb = wr_log.size();
    dc = done_cnt;
    do_start(12'h080, 13'd3);
    send_word(32'h21, ok);
    start = 1'b1; base_addr = 12'h300; num_words = 13'd1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'h22, ok);
    send_word(32'h23, ok);
    wait_done(20, seen, dcyc);
    @(negedge clk);
    vectors++;
    if (!seen || done_cnt - dc != 1 || wr_log.size() - lb != 3) begin
      miscompares++;
      $display("FAIL ignore_count: got done=%0d writes=%0d want 1/3", done_cnt - dc, wr_log.size() - lb);
    end else begin
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (wr_log[lb+j].addr !== 12'(12'h080 + j) || wr_log[lb+j].data !== 32'(32'h21 + j)) begin
          miscompares++;
          $display("FAIL ignore_write%0d: got %h/%h want %h/%h", j,
                   wr_log[lb+j].addr, wr_log[lb+j].data, 12'(12'h080 + j), 32'(32'h21 + j));
        end
      end
    end
  endtask

  task automatic test_reset_abort;
    bit ok, seen;
    int lb, dc, dcyc;
    lb = wr_log.size();
    dc = done_cnt;
    do_start(12'h0C0, 13'd4);
    send_word(32'h31, ok);
    send_word(32'h32, ok);
    vectors++;
    if (glb_we !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_setup: got glb_we=%b want 1", glb_we);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({GON_ready, glb_re, glb_we, busy, done} !== 5'b00000
        || glb_addr !== 12'h000 || glb_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_outputs: got ctrl=%b addr=%h wdata=%h want 00000/000/00000000",
               {GON_ready, glb_re, glb_we, busy, done}, glb_addr, glb_wdata);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (done_cnt != dc || wr_log.size() - lb != 2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_quiet: got done=%0d writes=%0d busy=%b want 0/2/0",
               done_cnt - dc, wr_log.size() - lb, busy);
    end
    lb = wr_log.size();
    do_start(12'h0D0, 13'd2);
    send_word(32'h55, ok);
    send_word(32'h66, ok);
    wait_done(20, seen, dcyc);
    @(negedge clk);
    vectors++;
    if (!seen || wr_log.size() - lb != 2) begin
      miscompares++;
      $display("FAIL abort_recover_count: got seen=%0d writes=%0d want 1/2", seen, wr_log.size() - lb);
    end else begin
      vectors++;
      if (wr_log[lb].addr !== 12'h0D0 || wr_log[lb].data !== 32'h55
          || wr_log[lb+1].addr !== 12'h0D1 || wr_log[lb+1].data !== 32'h66) begin
        miscompares++;
        $display("FAIL abort_recover_data: got %h/%h %h/%h want 0d0/55 0d1/66",
                 wr_log[lb].addr, wr_log[lb].data, wr_log[lb+1].addr, wr_log[lb+1].data);
      end
    end
  endtask

`ifdef GON_GLB_ACCUM_EN
  task automatic test_accum;
    bit ok, seen;
    int lb, rb, dcyc;
    logic [31:0] exp_data [3];
    exp_data[0] = 32'd105; exp_data[1] = 32'd107; exp_data[2] = 32'h0000_0000;
    @(negedge clk);
    pre_en = 1'b1; pre_addr = 12'h020; pre_data = 32'd100;
    @(negedge clk);
    pre_addr = 12'h021;
    @(negedge clk);
    pre_addr = 12'h022; pre_data = 32'hFFFF_FFFF;
    @(negedge clk);
    pre_en = 1'b0;
    lb = wr_log.size();
    rb = re_cyc.size();
    do_start(12'h020, 13'd3);
    send_word(32'd5, ok);
    send_word(32'd7, ok);
    send_word(32'd1, ok);
    wait_done(40, seen, dcyc);
    @(negedge clk);
    vectors++;
    if (!seen || wr_log.size() - lb != 3 || re_cyc.size() - rb != 3) begin
      miscompares++;
      $display("FAIL accum_count: got seen=%0d writes=%0d reads=%0d want 1/3/3",
               seen, wr_log.size() - lb, re_cyc.size() - rb);
    end else begin
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (wr_log[lb+j].addr !== 12'(12'h020 + j) || wr_log[lb+j].data !== exp_data[j]) begin
          miscompares++;
          $display("FAIL accum_write%0d: got %h/%h want %h/%h", j,
                   wr_log[lb+j].addr, wr_log[lb+j].data, 12'(12'h020 + j), exp_data[j]);
        end
        vectors++;
        if (wr_log[lb+j].cyc - re_cyc[rb+j] != 2) begin
          miscompares++;
          $display("FAIL accum_re_to_we%0d: got %0d cycles want 2", j, wr_log[lb+j].cyc - re_cyc[rb+j]);
        end
      end
    end
  endtask
`else
  task automatic test_no_read;
    vectors++;
    if (re_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL no_read: got %0d glb_re cycles want 0", re_cyc.size());
    end
  endtask
`endif

  task automatic test_exclusive;
    vectors++;
    if (overlap != 0) begin
      miscompares++;
      $display("FAIL re_we_exclusive: got %0d overlapping cycles want 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_stall();
    test_zero_wrap();
    test_start_ignored();
    test_reset_abort();
`ifdef GON_GLB_ACCUM_EN
    test_accum();
`else
    test_no_read();
`endif
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gon_glb_writeback.md
Name: gon_glb_writeback

Overview:
- Sits directly downstream of the global output network (GON) and consumes its slave-side valid/ready/data stream of PE partial sums or outputs.
- Writes each received word into the global buffer (GLB) SRAM at sequential addresses from a programmed base.
- Optionally accumulates each word onto the value already stored in the GLB (read-modify-write).
- Reports busy and done to the top-level controller.

Parameters:
- DATA_BITS, 32: width of the GON data word and the GLB data word.
- ADDR_BITS, 12: GLB word-address width.
- CNT_BITS, 13: width of the word-count config, so a full 2^ADDR_BITS transfer is expressible.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset; synchronous, active-low. Asserted when rst==0 at a clk edge.
- start, input, 1: one-cycle pulse; begins a transfer when idle.
- base_addr, input, ADDR_BITS: first GLB address, sampled on an accepted start.
- num_words, input, CNT_BITS: number of GON words to consume, sampled on an accepted start.
- GON_valid, input, 1: GON has a word.
- GON_ready, output, 1: writeback accepts a word.
- GON_data, input, DATA_BITS: word from GON.
- glb_re, output, 1: GLB read enable. Used only with ACCUM_EN; otherwise tied 0.
- glb_we, output, 1: GLB write enable.
- glb_addr, output, ADDR_BITS: GLB address for read or write.
- glb_wdata, output, DATA_BITS: GLB write data.
- glb_rdata, input, DATA_BITS: GLB read data, valid exactly 1 cycle after glb_re.
- busy, output, 1: high from an accepted start until done.
- done, output, 1: one-cycle pulse when the transfer completes.

Behaviour:
- Reset values: state=IDLE; GON_ready, glb_re, glb_we, busy, done all 0; glb_addr, glb_wdata, internal counter and data register all 0.
- Reset mid-transfer aborts immediately. No further GLB access; no done pulse.
- All outputs are registered-state decodes. GON_ready does not depend combinationally on GON_valid.
- FSM states: IDLE, RECV, RD, ADD, WR, DONE.
- IDLE:
  - start=1 and num_words!=0: latch base_addr and num_words, clear cnt, go to RECV.
  - start=1 and num_words==0: go to DONE (no GLB access).
  - start while not IDLE is ignored.
- RECV:
  - GON_ready=1.
  - On GON_valid && GON_ready, latch GON_data into dreg.
  - Next state is WR, or RD when ACCUM_EN.
  - No handshake: stay in RECV indefinitely (GON stall).
- RD: glb_re=1, glb_addr=base+cnt; go to ADD.
- ADD: dreg <= dreg + glb_rdata, modulo 2^DATA_BITS (wrap, no saturation); go to WR.
- WR:
  - glb_we=1, glb_addr=base+cnt, glb_wdata=dreg.
  - cnt <= cnt+1.
  - If cnt+1==num_words, go to DONE; else go to RECV.
- DONE: done=1 for one cycle, busy=0 in that cycle; go to IDLE.
- busy=1 in RECV/RD/ADD/WR.
- Address arithmetic: base+cnt truncated to ADDR_BITS, so addresses wrap past 2^ADDR_BITS-1 to 0.
- Throughput: one word per 2 cycles (plain) or 4 cycles (ACCUM_EN) when GON is always valid.
- Latency: GON handshake to glb_we is 1 cycle (plain) or 3 cycles (ACCUM_EN).
- Never more than one of glb_re/glb_we high in the same cycle.
- Words arriving after num_words have been consumed are not accepted; GON_ready=0 outside RECV.

Optional Feature:
- GON_GLB_ACCUM_EN:
  - Defined: RD and ADD states exist; each word is added to the current GLB content before write-back (psum accumulation).
  - Undefined: RD/ADD are not compiled; RECV goes straight to WR; glb_re is constant 0; glb_rdata is unused.

Test Plan:
- Plain write: base=0x010, num=4, GON sends 1,2,3,4 back-to-back. Writes land at 0x010..0x013 with data 1..4; done pulses 1 cycle after the last WR; GON_ready is high every other cycle.
- Backpressure/stall: num=3, GON_valid dropped for 5 cycles between words 1 and 2. GON_ready stays 1 during the gap, no glb_we in the gap, correct data order, done after the 3rd write.
- Zero and wrap: num=0 gives done on the cycle after start with no glb_we. base=0xFFE, num=4 writes addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Start ignored / reset abort: a second start while busy does not change base or count. rst=0 during WR of word 2 of 4 forces all outputs to 0 next cycle, no done pulse; a later transfer works normally.
- ACCUM_EN: GLB preloaded with 100 at 0x020–0x021 and 0xFFFFFFFF at 0x022. base=0x020, num=3, GON sends 5, 7, 1. Result is 105, 107, 0x00000000 (wrap). glb_re precedes each glb_we by 2 cycles.
